// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared time types, constants and BCD helpers for the alarm clock
package clock_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;
  localparam int SEC_PER_MIN   = 60;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } hms_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_t;

  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    int t;
    t = int'(v) / 10;
    return {4'(t), 4'(int'(v) - 10 * t)};
  endfunction

  // Digits must each be decimal and the pair must form a real hh:mm.
  function automatic logic bcd_valid(input logic [1:0] h1, input logic [3:0] h0,
                                     input logic [3:0] m1, input logic [3:0] m0);
    return (h0 <= 4'd9) && (m1 <= 4'd9) && (m0 <= 4'd9) &&
           (10 * int'(h1) + int'(h0) < HOURS_PER_DAY) &&
           (10 * int'(m1) + int'(m0) < MIN_PER_HOUR);
  endfunction

  function automatic logic [4:0] bcd_hour(input logic [1:0] h1, input logic [3:0] h0);
    return 5'(10 * int'(h1) + int'(h0));
  endfunction

  function automatic logic [5:0] bcd_min(input logic [3:0] m1, input logic [3:0] m0);
    return 6'(10 * int'(m1) + int'(m0));
  endfunction

endpackage

// File: rtl/hms_counter.sv
// rtl/hms_counter.sv - binary hh:mm:ss counter with validated BCD time load
module hms_counter
  import clock_pkg::*;
(
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       ld_time,
  input  logic [1:0] h_in1,
  input  logic [3:0] h_in0,
  input  logic [3:0] m_in1,
  input  logic [3:0] m_in0,
  output hms_t       tm
);

  logic load_ok;
  assign load_ok = ld_time && bcd_valid(h_in1, h_in0, m_in1, m_in0);

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      tm <= '0;
    end else if (load_ok) begin
      tm.hour <= bcd_hour(h_in1, h_in0);
      tm.min  <= bcd_min(m_in1, m_in0);
      tm.sec  <= '0;
    end else if (tm.sec == 6'(SEC_PER_MIN - 1)) begin
      tm.sec <= '0;
      if (tm.min == 6'(MIN_PER_HOUR - 1)) begin
        tm.min  <= '0;
        tm.hour <= (tm.hour == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : tm.hour + 5'd1;
      end else begin
        tm.min <= tm.min + 6'd1;
      end
    end else begin
      tm.sec <= tm.sec + 6'd1;
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// rtl/multi_alarm_clock.sv - 24h clock with alarm slots, snooze, stop and ring timeout
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter  int NUM_ALARMS = 4,
  parameter  int SNOOZE_MIN = 5,
  parameter  int MAX_SNOOZE = 3,
  parameter  int RING_SEC   = 60,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk_1s,
  input  logic                  reset,
  input  logic [1:0]            h_in1,
  input  logic [3:0]            h_in0,
  input  logic [3:0]            m_in1,
  input  logic [3:0]            m_in0,
  input  logic                  ld_time,
  input  logic                  ld_alarm,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] al_en,
  input  logic                  snooze,
  input  logic                  stop_al,
  output logic [1:0]            h_out1,
  output logic [3:0]            h_out0,
  output logic [3:0]            m_out1,
  output logic [3:0]            m_out0,
  output logic [3:0]            s_out1,
  output logic [3:0]            s_out0,
  output logic                  alarm,
  output logic [SEL_W-1:0]      alarm_src,
  output logic                  snoozed
);

  hms_t cur;
  logic [4:0] slot_hour [NUM_ALARMS];
  logic [5:0] slot_min  [NUM_ALARMS];
  alarm_state_t state, state_next;
  logic [7:0] ring_cnt, snooze_cnt;
  logic [4:0] tgt_hour, snz_hour;
  logic [5:0] tgt_min, snz_min;
  logic [6:0] min_sum;
  logic match;
  logic [SEL_W-1:0] match_idx;
  logic alarm_ok;
  logic [5:0] h_bcd;
  logic [7:0] m_bcd, s_bcd;

  hms_counter u_time (
    .clk_1s (clk_1s),
    .reset  (reset),
    .ld_time(ld_time),
    .h_in1  (h_in1),
    .h_in0  (h_in0),
    .m_in1  (m_in1),
    .m_in0  (m_in0),
    .tm     (cur)
  );

  assign alarm_ok = ld_alarm && bcd_valid(h_in1, h_in0, m_in1, m_in0) &&
                    (int'(alarm_sel) < NUM_ALARMS);

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        slot_hour[k] <= '0;
        slot_min[k]  <= '0;
      end
    end else if (alarm_ok) begin
      slot_hour[alarm_sel] <= bcd_hour(h_in1, h_in0);
      slot_min[alarm_sel]  <= bcd_min(m_in1, m_in0);
    end
  end

  // Scan downward so the lowest matching slot is the last one written.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (al_en[k] && cur.sec == 6'd0 && cur.hour == slot_hour[k] && cur.min == slot_min[k]) begin
        match     = 1'b1;
        match_idx = SEL_W'(k);
      end
    end
  end

  always_comb begin
    min_sum  = {1'b0, cur.min} + 7'(SNOOZE_MIN);
    snz_min  = min_sum[5:0];
    snz_hour = cur.hour;
    if (min_sum >= 7'(MIN_PER_HOUR)) begin
      snz_min  = 6'(min_sum - 7'(MIN_PER_HOUR));
      snz_hour = (cur.hour == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : cur.hour + 5'd1;
    end
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (match) state_next = ST_RING;
      ST_RING: begin
        if (stop_al || !al_en[alarm_src])                 state_next = ST_IDLE;
        else if (snooze && snooze_cnt < 8'(MAX_SNOOZE))   state_next = ST_SNOOZE;
        else if (ring_cnt == 8'(RING_SEC - 1))            state_next = ST_IDLE;
      end
      ST_SNOOZE: begin
        if (stop_al || !al_en[alarm_src]) state_next = ST_IDLE;
        else if (cur.sec == 6'd0 && cur.hour == tgt_hour && cur.min == tgt_min)
          state_next = ST_RING;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    alarm   = (state == ST_RING);
    snoozed = (state == ST_SNOOZE);
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      alarm_src  <= '0;
      snooze_cnt <= '0;
      ring_cnt   <= '0;
      tgt_hour   <= '0;
      tgt_min    <= '0;
    end else if (state == ST_IDLE && state_next == ST_RING) begin
      alarm_src  <= match_idx;
      snooze_cnt <= '0;
      ring_cnt   <= '0;
    end else if (state == ST_RING && state_next == ST_RING) begin
      ring_cnt <= ring_cnt + 8'd1;
    end else if (state == ST_RING && state_next == ST_SNOOZE) begin
      tgt_hour   <= snz_hour;
      tgt_min    <= snz_min;
      snooze_cnt <= snooze_cnt + 8'd1;
    end else if (state == ST_SNOOZE && state_next == ST_RING) begin
      ring_cnt <= '0;
    end
  end

  assign h_bcd = 6'(bin2bcd({1'b0, cur.hour}));
  assign m_bcd = bin2bcd(cur.min);
  assign s_bcd = bin2bcd(cur.sec);
  assign {h_out1, h_out0} = h_bcd;
  assign {m_out1, m_out0} = m_bcd;
  assign {s_out1, s_out0} = s_bcd;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb/tb_multi_alarm_clock.sv - directed and random checks against a seconds-of-day model
module tb_multi_alarm_clock;

  localparam int NA = 4, SNZ = 5, MAXS = 3, RSEC = 60;

  logic clk_1s = 1'b0;
  logic reset  = 1'b1;
  logic [1:0] h_in1 = '0;
  logic [3:0] h_in0 = '0, m_in1 = '0, m_in0 = '0;
  logic ld_time = 1'b0, ld_alarm = 1'b0, snooze = 1'b0, stop_al = 1'b0;
  logic [1:0] alarm_sel = '0;
  logic [NA-1:0] al_en = '0;
  logic [1:0] h_out1;
  logic [3:0] h_out0, m_out1, m_out0, s_out1, s_out0;
  logic alarm, snoozed;
  logic [1:0] alarm_src;

  int n_checks = 0, n_fail = 0;

  // Model: time as seconds of day, slots and snooze target as minutes of day.
  int m_time, m_src, m_scnt, m_rcnt, m_tgt, ms;
  int m_slot [NA];

  multi_alarm_clock #(.NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .MAX_SNOOZE(MAXS), .RING_SEC(RSEC)) dut (
    .clk_1s(clk_1s), .reset(reset), .h_in1(h_in1), .h_in0(h_in0), .m_in1(m_in1), .m_in0(m_in0),
    .ld_time(ld_time), .ld_alarm(ld_alarm), .alarm_sel(alarm_sel), .al_en(al_en),
    .snooze(snooze), .stop_al(stop_al), .h_out1(h_out1), .h_out0(h_out0), .m_out1(m_out1),
    .m_out0(m_out0), .s_out1(s_out1), .s_out0(s_out0), .alarm(alarm), .alarm_src(alarm_src),
    .snoozed(snoozed)
  );

  always #5 clk_1s = ~clk_1s;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] shown();
    return {2'b00, h_out1, h_out0, m_out1, m_out0, s_out1, s_out0};
  endfunction

  function automatic bit digits_ok(int h1, int h0, int m1, int m0);
    return h0 <= 9 && m1 <= 9 && m0 <= 9 && h1 * 10 + h0 < 24 && m1 * 10 + m0 < 60;
  endfunction

  task automatic model_reset();
    m_time = 0; ms = 0; m_src = 0; m_scnt = 0; m_rcnt = 0; m_tgt = 0;
    for (int k = 0; k < NA; k++) m_slot[k] = 0;
  endtask

  task automatic model_step();
    int hit = -1;
    int cur_min = m_time / 60;
    bit ok = digits_ok(int'(h_in1), int'(h_in0), int'(m_in1), int'(m_in0));
    int ld_min = (int'(h_in1) * 10 + int'(h_in0)) * 60 + int'(m_in1) * 10 + int'(m_in0);
    if (m_time % 60 == 0)
      for (int k = 0; k < NA; k++)
        if (hit < 0 && al_en[k] && m_slot[k] == cur_min) hit = k;
    if (ms == 0) begin
      if (hit >= 0) begin ms = 1; m_src = hit; m_scnt = 0; m_rcnt = 0; end
    end else if (ms == 1) begin
      if (stop_al || !al_en[m_src]) ms = 0;
      else if (snooze && m_scnt < MAXS) begin
        ms = 2; m_tgt = (cur_min + SNZ) % 1440; m_scnt++;
      end else if (m_rcnt == RSEC - 1) ms = 0;
      else m_rcnt++;
    end else begin
      if (stop_al || !al_en[m_src]) ms = 0;
      else if (m_time == m_tgt * 60) begin ms = 1; m_rcnt = 0; end
    end
    if (ld_time && ok) m_time = ld_min * 60;
    else m_time = (m_time + 1) % 86400;
    if (ld_alarm && ok && int'(alarm_sel) < NA) m_slot[alarm_sel] = ld_min;
  endtask

  task automatic check_all();
    int hh = m_time / 3600, mm = (m_time / 60) % 60, ss = m_time % 60;
    logic [23:0] exp_t = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    check("time", 32'(shown()), 32'(exp_t));
    check("alarm", 32'(alarm), 32'(ms == 1));
    check("alarm_src", 32'(alarm_src), 32'(m_src));
    check("snoozed", 32'(snoozed), 32'(ms == 2));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_1s);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk_1s);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_raw(input bit lt, input bit la, input int sel, input int h1, input int h0,
                          input int m1, input int m0);
    h_in1 = 2'(h1); h_in0 = 4'(h0); m_in1 = 4'(m1); m_in0 = 4'(m0);
    alarm_sel = 2'(sel); ld_time = lt; ld_alarm = la;
    tick();
    ld_time = 1'b0; ld_alarm = 1'b0;
  endtask

  task automatic set_time(input int h, input int m);
    load_raw(1, 0, 0, h / 10, h % 10, m / 10, m % 10);
  endtask

  task automatic set_alarm(input int sel, input int h, input int m);
    load_raw(0, 1, sel, h / 10, h % 10, m / 10, m % 10);
  endtask

  task automatic press_stop();
    stop_al = 1'b1;
    tick();
    stop_al = 1'b0;
  endtask

  task automatic wait_ring(input int bound);
    for (int i = 0; i < bound && !alarm; i++) tick();
    check("ring_reached", 32'(alarm), 32'd1);
  endtask

  initial begin
    int cnt;
    #1;
    model_reset();
    check_all();
    @(posedge clk_1s);
    #1;
    reset = 1'b0;
    check_all();

    repeat (86400) tick();
    check("day_wrap", 32'(shown()), 32'h000000);

    set_alarm(2, 7, 30);
    set_time(7, 29);
    al_en = 4'b0100;
    check("loaded", 32'(shown()), 32'h072900);
    repeat (60) tick();
    check("match_shown", 32'(shown()), 32'h073000);
    check("not_yet", 32'(alarm), 32'd0);
    tick();
    check("ring_rise", 32'(alarm), 32'd1);
    check("ring_src", 32'(alarm_src), 32'd2);
    press_stop();
    check("stopped", 32'(alarm), 32'd0);

    set_time(7, 29);
    repeat (61) tick();
    for (int p = 0; p < 4; p++) begin
      snooze = 1'b1;
      tick();
      snooze = 1'b0;
      if (p < MAXS) begin
        check("snoozed_hi", 32'(snoozed), 32'd1);
        check("snooze_quiet", 32'(alarm), 32'd0);
        wait_ring(400);
        if (p == 0) check("resume_time", 32'(shown()), 32'h073501);
      end else begin
        check("extra_snooze_ign", 32'(alarm), 32'd1);
      end
    end
    for (int i = 0; i < 200 && alarm; i++) tick();
    check("timeout_idle", 32'(alarm), 32'd0);

    set_time(7, 29);
    repeat (61) tick();
    cnt = alarm ? 1 : 0;
    for (int i = 0; i < 200 && alarm; i++) begin
      tick();
      if (alarm) cnt++;
    end
    check("ring_len", 32'(cnt), 32'(RSEC));

    al_en = '0;
    set_alarm(1, 6, 0);
    set_alarm(3, 6, 0);
    al_en = 4'b1010;
    set_time(5, 59);
    repeat (61) tick();
    check("low_idx_wins", 32'(alarm_src), 32'd1);
    al_en = 4'b1000;
    tick();
    check("en_clear_idle", 32'(alarm), 32'd0);

    al_en = '0;
    set_alarm(0, 8, 0);
    load_raw(1, 0, 0, 2, 5, 1, 0);
    load_raw(0, 1, 0, 0, 8, 0, 12);
    load_raw(0, 1, 0, 0, 8, 6, 0);
    load_raw(1, 1, 3, 0, 7, 5, 9);
    check("both_load", 32'(shown()), 32'h075900);
    al_en = 4'b0001;
    repeat (61) tick();
    check("slot0_kept", 32'(alarm), 32'd1);
    check("slot0_src", 32'(alarm_src), 32'd0);
    press_stop();
    set_time(8, 0);
    tick();
    check("load_on_alarm", 32'(alarm), 32'd1);

    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", 32'(alarm), 32'd0);
    check_all();
    @(posedge clk_1s);
    #1;
    reset = 1'b0;

    repeat (2500) begin
      h_in1     = ($urandom % 16 == 0) ? 2'd3 : 2'd0;
      h_in0     = ($urandom % 16 == 0) ? 4'd10 : 4'($urandom % 3);
      m_in1     = 4'($urandom % 2);
      m_in0     = ($urandom % 16 == 0) ? 4'd11 : 4'($urandom % 3);
      alarm_sel = 2'($urandom % 4);
      ld_time   = ($urandom % 40 == 0);
      ld_alarm  = ($urandom % 15 == 0);
      snooze    = ($urandom % 8 == 0);
      stop_al   = ($urandom % 30 == 0);
      if ($urandom % 20 == 0) al_en = 4'($urandom);
      if ($urandom % 500 == 0) do_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
